// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions: word width, magic constants, rotate helpers,
// table-size helper and the key-schedule state encoding.
package rc5_pkg;

  localparam int unsigned W = 16;

  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  // Number of round-key words for a given round count.
  function automatic int unsigned T_OF(input int unsigned rounds);
    return 2 * (rounds + 1);
  endfunction

  function automatic logic [W-1:0] rotl16(input logic [W-1:0] x, input logic [3:0] n);
    return (x << n) | (x >> (5'd16 - {1'b0, n}));
  endfunction

  function automatic logic [W-1:0] rotr16(input logic [W-1:0] x, input logic [3:0] n);
    return (x >> n) | (x << (5'd16 - {1'b0, n}));
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StMix,
    StDone
  } rc5_ks_state_e;

endpackage

// File: rtl/rc5_rotl16.sv
// Combinational 16-bit left barrel rotator, 4-bit amount, log-shifter form.
module rc5_rotl16 (
  input  logic [15:0] data_i,
  input  logic [3:0]  amt_i,
  output logic [15:0] data_o
);

  logic [15:0] s1, s2, s4;

  // Four rotate stages by 1, 2, 4 and 8 bits.
  always_comb begin
    s1     = amt_i[0] ? {data_i[14:0], data_i[15]}  : data_i;
    s2     = amt_i[1] ? {s1[13:0], s1[15:14]}       : s1;
    s4     = amt_i[2] ? {s2[11:0], s2[15:12]}       : s2;
    data_o = amt_i[3] ? {s4[7:0], s4[15:8]}         : s4;
  end

endmodule

// File: rtl/rc5_key_sched_16bit.sv
// RC5-16 key expansion: magic-constant table init then 3*max(T,C) mixing
// iterations, one per clock. The table is exposed through a combinational read port.
module rc5_key_sched_16bit
  import rc5_pkg::*;
#(
  parameter int unsigned ROUNDS    = 12,
  parameter int unsigned KEY_BYTES = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  key_start,
  input  logic [8*KEY_BYTES-1:0]                key,
  output logic                                  key_busy,
  output logic                                  key_done,
  input  logic [$clog2(T_OF(ROUNDS))-1:0]       s_rd_addr,
  output logic [15:0]                           s_rd_data
);

  localparam int unsigned T  = T_OF(ROUNDS);
  localparam int unsigned C  = KEY_BYTES / 2;
  localparam int unsigned M  = 3 * ((T > C) ? T : C);
  localparam int unsigned AW = $clog2(T);
  localparam int unsigned JW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned MW = $clog2(M);

  rc5_ks_state_e state_q, state_d;

  logic [15:0]   s_q [T];
  logic [15:0]   l_q [C];
  logic [15:0]   a_q, b_q;
  logic [15:0]   run_q;
  logic [AW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [MW-1:0] cnt_q;

  logic [15:0] a_sum, a_new, b_sum, b_new;
  logic [3:0]  b_amt;
  logic        i_last, j_last;

  // Mixing datapath: one adder chain feeding the two rotators.
  always_comb begin
    a_sum  = s_q[i_q] + a_q + b_q;
    b_sum  = l_q[j_q] + a_new + b_q;
    // Only the low nibble of A'+B sets the rotate amount.
    b_amt  = a_new[3:0] + b_q[3:0];
    i_last = (i_q == AW'(T - 1));
    j_last = (j_q == JW'(C - 1));
  end

  rc5_rotl16 u_rot_a (
    .data_i (a_sum),
    .amt_i  (4'd3),
    .data_o (a_new)
  );

  rc5_rotl16 u_rot_b (
    .data_i (b_sum),
    .amt_i  (b_amt),
    .data_o (b_new)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (key_start) state_d = StInit;
      StInit:         if (i_last) state_d = StMix;
      StMix:          if (cnt_q == MW'(M - 1)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Table, key words, mixing accumulators and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned n = 0; n < T; n++) s_q[n] <= '0;
      for (int unsigned n = 0; n < C; n++) l_q[n] <= '0;
      a_q   <= '0;
      b_q   <= '0;
      run_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (key_start) begin
            for (int unsigned n = 0; n < C; n++) l_q[n] <= key[16*n +: 16];
            a_q   <= '0;
            b_q   <= '0;
            run_q <= P16;
            i_q   <= '0;
            j_q   <= '0;
            cnt_q <= '0;
          end
        end
        StInit: begin
          s_q[i_q] <= run_q;
          run_q    <= run_q + Q16;
          i_q      <= i_last ? '0 : i_q + AW'(1);
        end
        StMix: begin
          s_q[i_q] <= a_new;
          l_q[j_q] <= b_new;
          a_q      <= a_new;
          b_q      <= b_new;
          i_q      <= i_last ? '0 : i_q + AW'(1);
          j_q      <= j_last ? '0 : j_q + JW'(1);
          cnt_q    <= cnt_q + MW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status and read port; out-of-range addresses read as zero.
  always_comb begin
    key_busy  = (state_q == StInit) || (state_q == StMix);
    key_done  = (state_q == StDone);
    s_rd_data = ({1'b0, s_rd_addr} < (AW + 1)'(T)) ? s_q[s_rd_addr] : 16'h0000;
  end

endmodule

// File: tb/tb_rc5_key_sched_16bit.sv
// Directed and model-checked bench for the RC5-16 key schedule.
module tb_rc5_key_sched_16bit;

  logic        clock;
  logic        reset;
  logic        key_start;
  logic [63:0] key;
  logic        key_busy;
  logic        key_done;
  logic [4:0]  s_rd_addr;
  logic [15:0] s_rd_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_s [26];

  rc5_key_sched_16bit #(
    .ROUNDS    (12),
    .KEY_BYTES (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_start (key_start),
    .key       (key),
    .key_busy  (key_busy),
    .key_done  (key_done),
    .s_rd_addr (s_rd_addr),
    .s_rd_data (s_rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] brot(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  // Independent reference for the full expanded table.
  task automatic model(input logic [63:0] k);
    logic [15:0] l [4];
    logic [15:0] a, b;
    int i, j;
    exp_s[0] = 16'hB7E1;
    for (int n = 1; n < 26; n++) exp_s[n] = exp_s[n-1] + 16'h9E37;
    for (int n = 0; n < 4; n++) l[n] = k[16*n +: 16];
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < 78; n++) begin
      a = brot(exp_s[i] + a + b, 3);
      exp_s[i] = a;
      b = brot(l[j] + a + b, int'((a + b) & 16'hF));
      l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  task automatic start(input logic [63:0] k);
    key       = k;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!key_done && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic check_table(input string tag, input logic [63:0] k);
    model(k);
    for (int a = 0; a < 26; a++) begin
      s_rd_addr = 5'(a);
      #1;
      check($sformatf("%s_s%0d", tag, a), 32'(s_rd_data), 32'(exp_s[a]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int a = 0; a < 26; a++) begin
      s_rd_addr = 5'(a);
      #1;
      check($sformatf("%s_s%0d", tag, a), 32'(s_rd_data), 32'h0);
    end
  endtask

  initial begin
    int n;
    logic [63:0] k1, k2;
    reset     = 1'b1;
    key_start = 1'b0;
    key       = '0;
    s_rd_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(key_busy), 32'h0);
    check("rst_done", 32'(key_done), 32'h0);
    check_zero("rst");

    // Zero key: directed values at init/mix boundaries and exact latency.
    start(64'h0);
    check("k0_busy", 32'(key_busy), 32'h1);
    check("k0_done_lo", 32'(key_done), 32'h0);
    for (int c = 0; c < 26; c++) tick();
    s_rd_addr = 5'd1;
    #1;
    check("k0_init_s1", 32'(s_rd_data), 32'h5618);
    s_rd_addr = 5'd25;
    #1;
    check("k0_init_s25", 32'(s_rd_data), 32'h2B40);
    tick();
    s_rd_addr = 5'd0;
    #1;
    check("k0_mix1_s0", 32'(s_rd_data), 32'hBF0D);
    for (int c = 27; c < 103; c++) tick();
    check("k0_done_103", 32'(key_done), 32'h0);
    check("k0_busy_103", 32'(key_busy), 32'h1);
    tick();
    check("k0_done_104", 32'(key_done), 32'h1);
    check("k0_busy_104", 32'(key_busy), 32'h0);
    check_table("k0", 64'h0);

    // Random keys against the reference model.
    for (int r = 0; r < 20; r++) begin
      k1 = {$urandom, $urandom};
      start(k1);
      wait_done(0, n);
      check($sformatf("rnd%0d_lat", r), 32'(n), 32'd104);
      check_table($sformatf("rnd%0d", r), k1);
    end

    // Start re-pulsed mid-expansion is ignored.
    k1 = 64'h0123_4567_89AB_CDEF;
    k2 = 64'hFEDC_BA98_7654_3210;
    start(k1);
    for (int c = 1; c < 50; c++) tick();
    key       = k2;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    wait_done(50, n);
    check("repulse_lat", 32'(n), 32'd104);
    check_table("repulse", k1);

    // Reset mid-expansion aborts and clears the table.
    start(k2);
    for (int c = 1; c < 60; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(key_busy), 32'h0);
    check("abort_done", 32'(key_done), 32'h0);
    check_zero("abort");
    start(k2);
    wait_done(0, n);
    check("fresh_lat", 32'(n), 32'd104);
    check_table("fresh", k2);

    // Back-to-back start from DONE.
    start(k1);
    check("b2b_done_drop", 32'(key_done), 32'h0);
    check("b2b_busy", 32'(key_busy), 32'h1);
    wait_done(0, n);
    check("b2b_lat", 32'(n), 32'd104);
    check_table("b2b", k1);
    for (int a = 26; a < 32; a++) begin
      s_rd_addr = 5'(a);
      #1;
      check($sformatf("oob_%0d", a), 32'(s_rd_data), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc5_key_sched_16bit.md
Name: rc5_key_sched_16bit

Overview:
- Key-expansion stage directly upstream of rc5_enc_16bit; the encryptor consumes its expanded table.
- Expands a b-byte secret key into the RC5-16 round-key table S[0..T-1], with T = 2*(ROUNDS+1).
- Runs the standard RC5 magic-constant init followed by the 3*max(T,C) mixing loop, one iteration per clock.
- The encryptor reads S through a random-access read port once key_done is high.

Parameters:
- ROUNDS, 12, number of RC5 rounds; T = 2*(ROUNDS+1) = 26 table words.
- KEY_BYTES, 8, secret-key length b in bytes; must be even and >= 2; C = KEY_BYTES/2 words.

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- key_start  in  1  request expansion; sampled on clock edge.
- key  in  8*KEY_BYTES  secret key; byte K[i] = key[8i+7:8i]; sampled with accepted key_start.
- key_busy  out  1  expansion in progress.
- key_done  out  1  level; S valid; held until next accepted start or reset.
- s_rd_addr  in  $clog2(T)  round-key index.
- s_rd_data  out  16  S[s_rd_addr], combinational read of table register.

Behaviour:
- Reset (sync, highest priority, any state): state=IDLE, key_busy=0, key_done=0, all S and L words = 0, A=B=0, counters=0.
- FSM states: IDLE, INIT, MIX, DONE.
- IDLE/DONE -> INIT on key_start=1 at edge E0.
  - At E0: load L[j] = {K[2j+1], K[2j]}, j = 0..C-1.
  - At E0: A=B=0, i=j=0, key_done=0, key_busy=1.
- key_start while INIT or MIX: ignored; key is not re-sampled.
- INIT: edge E0+k (k=1..T) writes S[k-1] = P16 + (k-1)*Q16 mod 2^16.
  - P16=16'hB7E1, Q16=16'h9E37.
  - Implement as running sum: S[0]=P16, S[k]=S[k-1]+Q16.
  - Edge E0+T -> MIX.
- MIX: M = 3*max(T,C) iterations (78 at defaults), one per edge E0+T+1 .. E0+T+M.
  - A' = rotl16(S[i]+A+B, 3); S[i] <= A'.
  - B' = rotl16(L[j]+A'+B, (A'+B) mod 16); L[j] <= B'.
  - A <= A', B <= B'; i <= (i+1) mod T; j <= (j+1) mod C.
  - Both wrap independently; wrap is required since T != C.
  - All additions are mod 2^16. Rotate amount is the low 4 bits of the 16-bit sum A'+B.
  - The last iteration edge -> DONE.
- DONE: key_done=1, key_busy=0. key_done first visible after edge E0+T+M (104 cycles at defaults).
- Reset mid-operation: abort immediately; key_done stays 0.
- Reads during INIT/MIX return the live table value; consumers must gate on key_done.
- s_rd_addr >= T returns 16'h0000.
- Single-cycle datapath: one adder chain and two barrel rotators. No multipliers.

Decomposition:
- rc5_pkg (shared with rc5_enc_16bit and a future decryptor):
  - W=16, P16, Q16.
  - rotl16/rotr16 functions.
  - Helper T_OF(rounds).
  - State enum typedef.
- One natural sub-module: rc5_rotl16, a combinational 16-bit barrel rotator with 4-bit amount. The encryptor reuses it.

Test Plan:
- Reset: assert reset 2 cycles -> key_busy=0, key_done=0, s_rd_data=0 for addr 0..25.
- key=0, pulse key_start at E0:
  - key_busy=1 after E0.
  - After E0+26: read addr 1 -> 16'h5618, addr 25 -> 16'h2B40.
  - After E0+27: addr 0 -> 16'hBF0D.
  - key_done rises after exactly E0+104.
- Golden model: random keys (≥20), full S[0..25] compared against the bench SV reference model after key_done. Then rc5_enc_16bit chained with plaintexts FFFF/00FF/FF00 matches the model ciphertext.
- key_start re-pulsed at E0+50 with a different key:
  - Ignored; done still at E0+104.
  - Table matches the first key.
- Reset asserted at E0+60 -> next cycle IDLE, busy=0, done=0, table zeroed. A fresh start completes normally in 104 cycles.
- Back-to-back: start while in DONE with a new key -> key_done drops after the start edge; new table valid 104 cycles later. Read addr 26..31 -> 16'h0000.
